arm_reg_file_p: RTL and testbench



---
 rtl/arm_reg_file_p.sv | 76 +++++++
 tb/tb_arm_reg_file_p.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/arm_reg_file_p.sv
// arm_reg_file_p: multi-port register file for the ARM datapath.
// Three combinational read ports (A, B, D) and two write ports.
// The highest-index register is the PC, which has an auto-increment path.
// Optional macro REG_BYPASS_EN forwards same-cycle write data to the read ports.
module arm_reg_file_p #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned PC_STEP  = 4,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [ADDR_W-1:0] RD,
  output logic [DATA_W-1:0] PA,
  output logic [DATA_W-1:0] PB,
  output logic [DATA_W-1:0] PD,
  input  logic              RF,
  input  logic [ADDR_W-1:0] RC,
  input  logic [DATA_W-1:0] PC,
  input  logic              RF2,
  input  logic [ADDR_W-1:0] RC2,
  input  logic [DATA_W-1:0] PC2,
  input  logic              Pc_inc,
  output logic [DATA_W-1:0] Pc_out,
  output logic              Wr_conflict
);

  localparam int unsigned NREG = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] nxt  [NREG];

  // Per-register next value: port 1 write, then port 2 write, then PC increment, then hold.
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      nxt[i] = regs[i];
      if (RF && (RC == ADDR_W'(i)))
        nxt[i] = PC;
      else if (RF2 && (RC2 == ADDR_W'(i)))
        nxt[i] = PC2;
      else if ((i == NREG - 1) && Pc_inc)
        nxt[i] = regs[i] + DATA_W'(PC_STEP);
    end
  end

  // Register state and dual-write conflict flag, cleared asynchronously.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int unsigned i = 0; i < NREG - 1; i++)
        regs[i] <= '0;
      regs[NREG-1] <= RESET_PC;
      Wr_conflict  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++)
        regs[i] <= nxt[i];
      Wr_conflict <= RF & RF2 & (RC == RC2);
    end
  end

`ifdef REG_BYPASS_EN
  // nxt already carries the highest-priority pending write (or the held value),
  // so reading it gives zero-latency forwarding with the same priority order.
  assign PA = nxt[RA];
  assign PB = nxt[RB];
  assign PD = nxt[RD];
`else
  assign PA = regs[RA];
  assign PB = regs[RB];
  assign PD = regs[RD];
`endif

  assign Pc_out = regs[NREG-1];

endmodule

// File: tb/tb_arm_reg_file_p.sv
// Scoreboard testbench for arm_reg_file_p (16 x 32, RESET_PC = 0x100).
module tb_arm_reg_file_p;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic [3:0]  RA = 4'd3, RB = 4'd3, RD = 4'd3, RC = '0, RC2 = '0;
  logic [31:0] PA, PB, PD, PC = '0, PC2 = '0, Pc_out;
  logic        RF = 1'b0, RF2 = 1'b0, Pc_inc = 1'b0, Wr_conflict;

  arm_reg_file_p #(
    .DATA_W(32), .ADDR_W(4), .PC_STEP(4), .RESET_PC(32'h100)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .RA(RA), .RB(RB), .RD(RD),
    .PA(PA), .PB(PB), .PD(PD),
    .RF(RF), .RC(RC), .PC(PC),
    .RF2(RF2), .RC2(RC2), .PC2(PC2),
    .Pc_inc(Pc_inc), .Pc_out(Pc_out), .Wr_conflict(Wr_conflict)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] pa, pb, pd, pcout;
    logic        wc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m [16];
  logic        mc;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Value register a holds after this cycle's edge: start from the stored value,
  // then let each source overwrite in increasing priority.
  function automatic logic [31:0] after_edge(input logic [3:0] a);
    logic [31:0] v;
    v = m[a];
    if (Pc_inc && a == 4'd15) v = m[15] + 32'd4;
    if (RF2 && RC2 == a)      v = PC2;
    if (RF && RC == a)        v = PC;
    return v;
  endfunction

  function automatic logic [31:0] rd_exp(input logic [3:0] a);
`ifdef REG_BYPASS_EN
    return after_edge(a);
`else
    return m[a];
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m[i] = '0;
    m[15] = 32'h100;
    mc = 1'b0;
  endtask

  // Drive one cycle of stimulus (called just after a rising edge), queue the
  // expected outputs, then advance the model across the next edge.
  task automatic cyc(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rd,
                     input logic rf, input logic [3:0] rc, input logic [31:0] pc,
                     input logic rf2, input logic [3:0] rc2, input logic [31:0] pc2,
                     input logic inc);
    exp_t e;
    logic [31:0] nv [16];
    RA = ra; RB = rb; RD = rd; RF = rf; RC = rc; PC = pc;
    RF2 = rf2; RC2 = rc2; PC2 = pc2; Pc_inc = inc;
    e.pa = rd_exp(ra); e.pb = rd_exp(rb); e.pd = rd_exp(rd);
    e.pcout = m[15]; e.wc = mc;
    sb.push_back(e);
    @(posedge Clk);
    for (int i = 0; i < 16; i++) nv[i] = after_edge(4'(i));
    for (int i = 0; i < 16; i++) m[i] = nv[i];
    mc = rf & rf2 & (rc == rc2);
    #1;
  endtask

  task automatic idle(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rd);
    cyc(ra, rb, rd, 1'b0, 4'hx, 32'hx, 1'b0, 4'hx, 32'hx, 1'b0);
  endtask

  // Monitor: on each falling edge with a queued expectation, compare all outputs.
  always @(negedge Clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("PA", PA, e.pa);
      chk("PB", PB, e.pb);
      chk("PD", PD, e.pd);
      chk("Pc_out", Pc_out, e.pcout);
      chk("Wr_conflict", {31'd0, Wr_conflict}, {31'd0, e.wc});
    end
  end

  initial begin
    // Asynchronous reset in mid-cycle, checked before any clock edge.
    #3 Rst_n = 1'b0;
    #1;
    chk("rst_PA", PA, 32'h0);
    chk("rst_PB", PB, 32'h0);
    chk("rst_PD", PD, 32'h0);
    chk("rst_Pc_out", Pc_out, 32'h100);
    chk("rst_Wr_conflict", {31'd0, Wr_conflict}, 32'h0);
    model_reset();
    #8 Rst_n = 1'b1;
    @(posedge Clk); #1;

    // PC increment, write-wins over increment, and wrap.
    repeat (3) cyc(4'd15, 4'd0, 4'd1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1);
    cyc(4'd15, 4'd15, 4'd15, 1'b1, 4'd15, 32'h200, 1'b0, 4'd0, 32'd0, 1'b1);
    cyc(4'd15, 4'd15, 4'd15, 1'b1, 4'd15, 32'hFFFF_FFFC, 1'b0, 4'd0, 32'd0, 1'b0);
    cyc(4'd15, 4'd15, 4'd15, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1);
    idle(4'd15, 4'd15, 4'd15);

    // Write sweep of R0..R14 via port 1 with offset read selects.
    for (int i = 0; i < 15; i++)
      cyc(4'(i), 4'(i + 15), 4'd15, 1'b1, 4'(i), 32'(100 + 4 * i), 1'b0, 4'd0, 32'd0, 1'b0);
    idle(4'd14, 4'd13, 4'd15);

    // Dual write, distinct addresses.
    cyc(4'd2, 4'd5, 4'd0, 1'b1, 4'd2, 32'h11, 1'b1, 4'd5, 32'h22, 1'b0);
    idle(4'd2, 4'd5, 4'd0);

    // Dual write, same address: port 1 wins and conflict flag lasts one cycle.
    cyc(4'd7, 4'd7, 4'd7, 1'b1, 4'd7, 32'd35, 1'b1, 4'd7, 32'd99, 1'b0);
    idle(4'd7, 4'd7, 4'd7);
    idle(4'd7, 4'd7, 4'd7);

    // Same-cycle write and read of R4.
    cyc(4'd4, 4'd4, 4'd3, 1'b1, 4'd4, 32'hDEAD, 1'b0, 4'd0, 32'd0, 1'b0);
    idle(4'd4, 4'd4, 4'd4);

    // Randomised traffic with a bias towards colliding write selects.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] rc, rc2;
      rc  = 4'($urandom_range(0, 15));
      rc2 = ($urandom_range(0, 3) == 0) ? rc : 4'($urandom_range(0, 15));
      cyc(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          1'($urandom), rc, $urandom, 1'($urandom), rc2, $urandom, 1'($urandom));
    end

    // Reset asserted during a pending write discards it.
    RA = 4'd3; RB = 4'd3; RD = 4'd15;
    RF = 1'b1; RC = 4'd3; PC = 32'd55; RF2 = 1'b0; Pc_inc = 1'b1;
    #2 Rst_n = 1'b0;
    #1;
    chk("midrst_PA", PA, 32'h0);
    chk("midrst_Pc_out", Pc_out, 32'h100);
    model_reset();
    @(posedge Clk);
    #2 Rst_n = 1'b1;
    idle(4'd3, 4'd0, 4'd15);
    cyc(4'd3, 4'd3, 4'd3, 1'b1, 4'd3, 32'd77, 1'b0, 4'd0, 32'd0, 1'b0);
    idle(4'd3, 4'd15, 4'd0);

    for (int t = 0; t < 10 && sb.size() > 0; t++) @(posedge Clk);
    #6;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
